// File: rtl/lfsr_updown_param_if.sv
// Control/status bundle for lfsr_updown_param: step, load and burst requests in,
// LFSR state, position and status pulses out.
interface lfsr_updown_param_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic             up_down;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic [WIDTH-1:0] burst_len;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] position;
   logic             wrap;
   logic             busy;
   logic             done;
   logic             lockup;

   modport master (
      output enable, up_down, load, load_value, start, burst_len,
      input  count, position, wrap, busy, done, lockup
   );

   modport slave (
      input  enable, up_down, load, load_value, start, burst_len,
      output count, position, wrap, busy, done, lockup
   );
endinterface

// File: rtl/lfsr_updown_param.sv
// Parametrised up/down XNOR LFSR with seed load, position tracking, wrap pulse and burst engine.
// Optional all-ones lockup recovery is enabled by defining LFSR_LOCKUP_GUARD_EN.
module lfsr_updown_param #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
   parameter logic [WIDTH-1:0] SEED  = '0
) (
   input logic                clk,
   input logic                reset,
   lfsr_updown_param_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Largest position value: the sequence has 2^WIDTH-1 states.
   localparam logic [WIDTH-1:0] POS_MAX = {WIDTH{1'b1}} - WIDTH'(1);

   function automatic logic [WIDTH-1:0] fwd_step(input logic [WIDTH-1:0] c);
      return {c[WIDTH-2:0], ~^(c & TAPS)};
   endfunction

   function automatic logic [WIDTH-1:0] rev_step(input logic [WIDTH-1:0] c);
      return {~(c[0] ^ (^(c[WIDTH-1:1] & TAPS[WIDTH-2:0]))), c[WIDTH-1:1]};
   endfunction

   function automatic logic [WIDTH-1:0] pos_inc(input logic [WIDTH-1:0] p);
      return (p == POS_MAX) ? '0 : p + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] pos_dec(input logic [WIDTH-1:0] p);
      return (p == '0) ? POS_MAX : p - WIDTH'(1);
   endfunction

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_remain;
   logic             r_dir;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_pos;
   logic             r_wrap;
   logic             r_busy;
   logic             r_done;
   logic             r_lockup;

   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] w_remain_nxt;
   logic             w_start_acc;
   logic             w_step;
   logic             w_dir;
   logic             w_guard;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_pos_nxt;
   logic             w_wrap_nxt;
   logic             w_lock_nxt;

`ifdef LFSR_LOCKUP_GUARD_EN
   assign w_guard = &r_count;
`else
   assign w_guard = 1'b0;
`endif

   // Burst FSM and step request; load overrides everything below reset.
   always_comb begin
      w_state_nxt  = r_state;
      w_remain_nxt = r_remain;
      w_start_acc  = 1'b0;
      w_step       = 1'b0;
      w_dir        = bus.up_down;
      if (bus.load) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  w_start_acc  = 1'b1;
                  w_remain_nxt = bus.burst_len;
                  w_state_nxt  = (bus.burst_len == '0) ? DONE : RUN;
               end else if (bus.enable) begin
                  w_step = 1'b1;
               end
            end
            RUN: begin
               w_step       = 1'b1;
               w_dir        = r_dir;
               w_remain_nxt = r_remain - WIDTH'(1);
               if (r_remain == WIDTH'(1)) w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      w_pos_nxt   = r_pos;
      w_wrap_nxt  = 1'b0;
      w_lock_nxt  = 1'b0;
      if (bus.load) begin
         w_count_nxt = bus.load_value;
         w_pos_nxt   = '0;
`ifdef LFSR_LOCKUP_GUARD_EN
         if (&bus.load_value) begin
            w_count_nxt = SEED;
            w_lock_nxt  = 1'b1;
         end
`endif
      end else if (w_guard) begin
         w_count_nxt = SEED;
         w_pos_nxt   = '0;
         w_lock_nxt  = 1'b1;
      end else if (w_step) begin
         w_count_nxt = w_dir ? fwd_step(r_count) : rev_step(r_count);
         w_pos_nxt   = w_dir ? pos_inc(r_pos) : pos_dec(r_pos);
         w_wrap_nxt  = (w_pos_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_count  <= SEED;
         r_pos    <= '0;
         r_wrap   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_lockup <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_pos    <= w_pos_nxt;
         r_wrap   <= w_wrap_nxt;
         r_busy   <= (w_state_nxt == RUN);
         r_done   <= (w_state_nxt == DONE);
         r_lockup <= w_lock_nxt;
      end
   end

   // Burst bookkeeping carries no reset: it is only read while RUN.
   always_ff @(posedge clk) begin
      r_remain <= w_remain_nxt;
      if (w_start_acc) r_dir <= bus.up_down;
   end

   assign bus.count    = r_count;
   assign bus.position = r_pos;
   assign bus.wrap     = r_wrap;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.lockup   = r_lockup;

endmodule

// File: tb/tb_lfsr_updown_param.sv
// Directed bench for lfsr_updown_param (WIDTH=8, TAPS=0xB8, SEED=0): vector table plus burst,
// abort, reset and all-ones load sequences.
module tb_lfsr_updown_param;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   lfsr_updown_param_if #(.WIDTH(8)) bus ();

   lfsr_updown_param #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h00)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en, ud, ld;
      logic [7:0] ldv;
      logic       st;
      logic [7:0] bl;
      logic [7:0] c, p;
      logic       w, b, d;
   } vec_t;

   vec_t vecs[15];
   bit   seen[256];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic en, ud, ld, input logic [7:0] ldv,
                        input logic st, input logic [7:0] bl);
      bus.enable     = en;
      bus.up_down    = ud;
      bus.load       = ld;
      bus.load_value = ldv;
      bus.start      = st;
      bus.burst_len  = bl;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int busy_cycles;
      int distinct;
      reset = 1'b1;
      drive(0, 1, 0, 8'h00, 0, 8'h00);

      //          en ud ld ldv    st bl     count  pos    w  b  d
      vecs[0]  = '{1, 1, 0, 8'h00, 0, 8'h00, 8'h01, 8'd1,   0, 0, 0};
      vecs[1]  = '{1, 1, 0, 8'h00, 0, 8'h00, 8'h03, 8'd2,   0, 0, 0};
      vecs[2]  = '{1, 1, 0, 8'h00, 0, 8'h00, 8'h07, 8'd3,   0, 0, 0};
      vecs[3]  = '{1, 1, 0, 8'h00, 0, 8'h00, 8'h0F, 8'd4,   0, 0, 0};
      vecs[4]  = '{1, 1, 0, 8'h00, 0, 8'h00, 8'h1E, 8'd5,   0, 0, 0};
      vecs[5]  = '{0, 1, 0, 8'h00, 0, 8'h00, 8'h1E, 8'd5,   0, 0, 0};
      vecs[6]  = '{0, 1, 1, 8'h01, 0, 8'h00, 8'h01, 8'd0,   0, 0, 0};
      vecs[7]  = '{1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'd254, 0, 0, 0};
      vecs[8]  = '{1, 1, 0, 8'h00, 0, 8'h00, 8'h01, 8'd0,   1, 0, 0};
      vecs[9]  = '{1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'd254, 0, 0, 0};
      vecs[10] = '{1, 1, 1, 8'h5A, 1, 8'h03, 8'h5A, 8'd0,   0, 0, 0};
      vecs[11] = '{0, 1, 0, 8'h00, 0, 8'h00, 8'h5A, 8'd0,   0, 0, 0};
      vecs[12] = '{1, 1, 0, 8'h00, 1, 8'h00, 8'h5A, 8'd0,   0, 0, 1};
      vecs[13] = '{1, 1, 0, 8'h00, 1, 8'h02, 8'h5A, 8'd0,   0, 0, 0};
      vecs[14] = '{0, 1, 0, 8'h00, 0, 8'h00, 8'h5A, 8'd0,   0, 0, 0};

      do_reset();
      chk("reset_count",  bus.count, 8'h00);
      chk("reset_pos",    bus.position, 8'd0);
      chk("reset_wrap",   bus.wrap, 1'b0);
      chk("reset_busy",   bus.busy, 1'b0);
      chk("reset_done",   bus.done, 1'b0);
      chk("reset_lockup", bus.lockup, 1'b0);

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].en, vecs[i].ud, vecs[i].ld, vecs[i].ldv, vecs[i].st, vecs[i].bl);
         tick();
         chk($sformatf("v%0d_count", i), bus.count, vecs[i].c);
         chk($sformatf("v%0d_pos", i),   bus.position, vecs[i].p);
         chk($sformatf("v%0d_wrap", i),  bus.wrap, vecs[i].w);
         chk($sformatf("v%0d_busy", i),  bus.busy, vecs[i].b);
         chk($sformatf("v%0d_done", i),  bus.done, vecs[i].d);
         chk($sformatf("v%0d_lock", i),  bus.lockup, 1'b0);
      end

      // Full-period forward burst; conflicting inputs held during RUN and DONE must be ignored.
      drive(0, 1, 0, 8'h00, 0, 8'h00);
      do_reset();
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      drive(0, 1, 0, 8'h00, 1, 8'd255);
      tick();
      drive(1, 0, 0, 8'h00, 1, 8'd5);
      busy_cycles = 0;
      while (bus.busy === 1'b1 && busy_cycles < 400) begin
         seen[bus.count] = 1'b1;
         busy_cycles++;
         tick();
      end
      distinct = 0;
      for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
      chk("burst_busy_cycles", busy_cycles, 255);
      chk("burst_distinct",    distinct, 255);
      chk("burst_end_count",   bus.count, 8'h00);
      chk("burst_end_pos",     bus.position, 8'd0);
      chk("burst_end_done",    bus.done, 1'b1);
      chk("burst_end_wrap",    bus.wrap, 1'b1);
      tick();
      chk("after_done_count",  bus.count, 8'h00);
      chk("after_done_done",   bus.done, 1'b0);
      chk("after_done_busy",   bus.busy, 1'b0);
      chk("after_done_wrap",   bus.wrap, 1'b0);
      drive(0, 1, 0, 8'h00, 0, 8'h00);

      // Load on the second busy cycle aborts the burst without done.
      drive(0, 1, 0, 8'h00, 1, 8'd3);
      tick();
      drive(0, 1, 0, 8'h00, 0, 8'h00);
      chk("abort_busy1",  bus.busy, 1'b1);
      tick();
      chk("abort_busy2",  bus.busy, 1'b1);
      chk("abort_count2", bus.count, 8'h01);
      drive(0, 1, 1, 8'h5A, 0, 8'h00);
      tick();
      drive(0, 1, 0, 8'h00, 0, 8'h00);
      chk("abort_count",  bus.count, 8'h5A);
      chk("abort_pos",    bus.position, 8'd0);
      chk("abort_busy",   bus.busy, 1'b0);
      chk("abort_done",   bus.done, 1'b0);
      tick();
      chk("abort_done_late", bus.done, 1'b0);
      chk("abort_count_hold", bus.count, 8'h5A);
      drive(0, 1, 0, 8'h00, 1, 8'd1);
      tick();
      drive(0, 1, 0, 8'h00, 0, 8'h00);
      chk("restart_busy", bus.busy, 1'b1);
      tick();
      chk("restart_count", bus.count, 8'hB5);
      chk("restart_pos",   bus.position, 8'd1);
      chk("restart_done",  bus.done, 1'b1);

      // Reset in the middle of a burst.
      tick();
      drive(0, 1, 0, 8'h00, 1, 8'd5);
      tick();
      drive(0, 1, 0, 8'h00, 0, 8'h00);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_busy",  bus.busy, 1'b0);
      chk("midrst_count", bus.count, 8'h00);
      chk("midrst_pos",   bus.position, 8'd0);
      tick();
      chk("midrst_done",  bus.done, 1'b0);
      chk("midrst_idle_count", bus.count, 8'h00);

      // All-ones load.
      drive(0, 1, 1, 8'hFF, 0, 8'h00);
      tick();
`ifdef LFSR_LOCKUP_GUARD_EN
      chk("ff_load_count",  bus.count, 8'h00);
      chk("ff_load_lockup", bus.lockup, 1'b1);
      chk("ff_load_pos",    bus.position, 8'd0);
      drive(0, 1, 0, 8'h00, 0, 8'h00);
      tick();
      chk("ff_lockup_pulse", bus.lockup, 1'b0);
`else
      chk("ff_load_count",  bus.count, 8'hFF);
      chk("ff_load_lockup", bus.lockup, 1'b0);
      drive(1, 1, 0, 8'h00, 0, 8'h00);
      tick();
      tick();
      chk("ff_stuck_count", bus.count, 8'hFF);
      chk("ff_stuck_lockup", bus.lockup, 1'b0);
      chk("ff_stuck_pos",   bus.position, 8'd2);
`endif
      drive(0, 1, 0, 8'h00, 0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
